// File: rtl/nios_ocimem_pkg.sv
// Shared types and constants for the Nios OCI RAM access arbiter.
// The JTAG slot stores a word address of up to SLOT_ADDR_W bits, zero-extended.
package nios_ocimem_pkg;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 2;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int OCI_DATA_W   = 32;
  localparam int SLOT_ADDR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_J_WR     = 3'd1,
    ST_J_RD     = 3'd2,
    ST_J_RD_CAP = 3'd3,
    ST_A_WR     = 3'd4,
    ST_A_RD     = 3'd5,
    ST_A_RD_CAP = 3'd6
  } arb_state_e;

  typedef enum logic {
    GNT_JTAG   = 1'b0,
    GNT_AVALON = 1'b1
  } grant_e;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [OCI_DATA_W-1:0]  data;
  } jtag_slot_t;

  localparam jtag_slot_t SLOT_EMPTY = '{valid: 1'b0, is_write: 1'b0,
                                        addr: {SLOT_ADDR_W{1'b0}},
                                        data: {OCI_DATA_W{1'b0}}};

  function automatic logic is_jtag_state(input arb_state_e st);
    return (st == ST_J_WR) || (st == ST_J_RD) || (st == ST_J_RD_CAP);
  endfunction

endpackage

// File: rtl/nios_ocimem_jtag_slot.sv
// JTAG side of the OCI RAM arbiter: single pending-op slot, MonAReg/MonDReg,
// auto-increment and the sticky overrun flag.
module nios_ocimem_jtag_slot
  import nios_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  slot_clear,
  input  logic                  rd_capture,
  input  logic [OCI_DATA_W-1:0] rd_data,
  output jtag_slot_t            slot,
  output logic [ADDR_W-1:0]     mon_a_reg,
  output logic [OCI_DATA_W-1:0] mon_d_reg,
  output logic                  overrun
);

  jtag_slot_t              slot_r, slot_nxt_s;
  logic [ADDR_W-1:0]       mon_a_reg_r, mon_a_nxt_s;
  logic [OCI_DATA_W-1:0]   mon_d_reg_r, mon_d_nxt_s;
  logic                    overrun_r, overrun_nxt_s;
  logic                    op_req_s, accept_s;
  logic                    unused_jdo_s;

  assign unused_jdo_s = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_ADDR_LSB-1:0]};

  // Slot capture, address update and overrun detection; an op strobe always
  // captures the pre-load MonAReg, while an address load overrides the increment.
  always_comb begin
    op_req_s      = take_action_ocimem_b | take_no_action_ocimem_a;
    accept_s      = op_req_s & ~slot_r.valid;
    slot_nxt_s    = slot_r;
    mon_a_nxt_s   = mon_a_reg_r;
    mon_d_nxt_s   = mon_d_reg_r;
    overrun_nxt_s = overrun_r | (op_req_s & slot_r.valid);
    if (accept_s) begin
      slot_nxt_s.valid    = 1'b1;
      slot_nxt_s.is_write = take_action_ocimem_b;
      slot_nxt_s.addr     = SLOT_ADDR_W'(mon_a_reg_r);
      if (take_action_ocimem_b) begin
        slot_nxt_s.data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
      end else begin
        slot_nxt_s.data = {OCI_DATA_W{1'b0}};
      end
    end else if (slot_clear) begin
      slot_nxt_s.valid = 1'b0;
    end else begin
      slot_nxt_s = slot_r;
    end
    if (take_action_ocimem_a) begin
      mon_a_nxt_s = jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
    end else if (accept_s) begin
      mon_a_nxt_s = mon_a_reg_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      mon_a_nxt_s = mon_a_reg_r;
    end
    if (rd_capture) begin
      mon_d_nxt_s = rd_data;
    end else if (accept_s && take_action_ocimem_b) begin
      mon_d_nxt_s = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    end else begin
      mon_d_nxt_s = mon_d_reg_r;
    end
  end

  // JTAG-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r      <= SLOT_EMPTY;
      mon_a_reg_r <= {ADDR_W{1'b0}};
      mon_d_reg_r <= {OCI_DATA_W{1'b0}};
      overrun_r   <= 1'b0;
    end else begin
      slot_r      <= slot_nxt_s;
      mon_a_reg_r <= mon_a_nxt_s;
      mon_d_reg_r <= mon_d_nxt_s;
      overrun_r   <= overrun_nxt_s;
    end
  end

  assign slot      = slot_r;
  assign mon_a_reg = mon_a_reg_r;
  assign mon_d_reg = mon_d_reg_r;
  assign overrun   = overrun_r;

endmodule

// File: rtl/nios_ocimem_access_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between the JTAG debug
// slot and the CPU Avalon debug slave; RAM control is registered from next state.
module nios_ocimem_access_arbiter
  import nios_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  arb_state_e        state_r, state_nxt_s;
  grant_e            last_grant_r, grant_nxt_s;
  jtag_slot_t        slot_s;
  logic              slot_clear_s, rd_capture_s, av_req_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_nxt_s;
  logic              ram_wren_r, ram_wren_nxt_s;
  logic [DATA_W-1:0] ram_wdata_r, ram_wdata_nxt_s;
  logic [DATA_W-1:0] av_readdata_r;
  logic              av_readdatavalid_r;

  assign av_req_s = av_read | av_write;

  nios_ocimem_jtag_slot #(.ADDR_W(ADDR_W)) u_jtag_slot (
    .clk                     (clk),
    .rst_n                   (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .slot_clear              (slot_clear_s),
    .rd_capture              (rd_capture_s),
    .rd_data                 (ram_rdata),
    .slot                    (slot_s),
    .mon_a_reg               (MonAReg),
    .mon_d_reg               (MonDReg),
    .overrun                 (jtag_overrun)
  );

  if (ADDR_W < SLOT_ADDR_W) begin : g_addr_pad
    logic unused_addr_s;
    assign unused_addr_s = ^slot_s.addr[SLOT_ADDR_W-1:ADDR_W];
  end

  // FSM state and last-grant registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GNT_AVALON;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= grant_nxt_s;
    end
  end

  // Next state, arbitration and slot handshakes; a tie goes to the side not served last.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = last_grant_r;
    slot_clear_s = 1'b0;
    rd_capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (slot_s.valid && (!av_req_s || (last_grant_r == GNT_AVALON))) begin
          grant_nxt_s = GNT_JTAG;
          if (slot_s.is_write) state_nxt_s = ST_J_WR;
          else                 state_nxt_s = ST_J_RD;
        end else if (av_req_s) begin
          grant_nxt_s = GNT_AVALON;
          if (av_write) state_nxt_s = ST_A_WR;
          else          state_nxt_s = ST_A_RD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_J_WR: begin
        slot_clear_s = 1'b1;
        state_nxt_s  = ST_IDLE;
      end
      ST_J_RD:     state_nxt_s = ST_J_RD_CAP;
      ST_J_RD_CAP: begin
        rd_capture_s = 1'b1;
        slot_clear_s = 1'b1;
        state_nxt_s  = ST_IDLE;
      end
      ST_A_WR:     state_nxt_s = ST_IDLE;
      ST_A_RD:     state_nxt_s = ST_A_RD_CAP;
      ST_A_RD_CAP: state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // RAM port values for the state being entered; address holds when idle.
  always_comb begin
    ram_addr_nxt_s  = ram_addr_r;
    ram_wren_nxt_s  = 1'b0;
    ram_wdata_nxt_s = ram_wdata_r;
    case (state_nxt_s)
      ST_J_WR: begin
        ram_addr_nxt_s  = slot_s.addr[ADDR_W-1:0];
        ram_wren_nxt_s  = 1'b1;
        ram_wdata_nxt_s = slot_s.data;
      end
      ST_J_RD: ram_addr_nxt_s = slot_s.addr[ADDR_W-1:0];
      ST_A_WR: begin
        ram_addr_nxt_s  = av_address;
        ram_wren_nxt_s  = 1'b1;
        ram_wdata_nxt_s = av_writedata;
      end
      ST_A_RD: ram_addr_nxt_s = av_address;
      default: ram_wren_nxt_s = 1'b0;
    endcase
  end

  // Registered RAM port and Avalon read-return outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_r         <= {ADDR_W{1'b0}};
      ram_wren_r         <= 1'b0;
      ram_wdata_r        <= {DATA_W{1'b0}};
      av_readdata_r      <= {DATA_W{1'b0}};
      av_readdatavalid_r <= 1'b0;
    end else begin
      ram_addr_r         <= ram_addr_nxt_s;
      ram_wren_r         <= ram_wren_nxt_s;
      ram_wdata_r        <= ram_wdata_nxt_s;
      av_readdatavalid_r <= (state_r == ST_A_RD_CAP);
      if (state_r == ST_A_RD_CAP) av_readdata_r <= ram_rdata;
      else                        av_readdata_r <= av_readdata_r;
    end
  end

  // Avalon stall: released only in the command-accept states.
  always_comb begin
    case (state_r)
      ST_IDLE:          av_waitrequest = av_req_s;
      ST_A_WR, ST_A_RD: av_waitrequest = 1'b0;
      default:          av_waitrequest = 1'b1;
    endcase
  end

  assign jtag_busy        = slot_s.valid | is_jtag_state(state_r);
  assign ram_addr         = ram_addr_r;
  assign ram_wren         = ram_wren_r;
  assign ram_wdata        = ram_wdata_r;
  assign av_readdata      = av_readdata_r;
  assign av_readdatavalid = av_readdatavalid_r;

endmodule

// File: tb/tb_nios_ocimem_access_arbiter.sv
// Directed bench for nios_ocimem_access_arbiter with a 256-word, 1-cycle-latency RAM model.
module tb_nios_ocimem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = 38'd0;
  logic        take_a = 1'b0, take_b = 1'b0, take_no_a = 1'b0;
  logic [7:0]  av_address = 8'd0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic [31:0] av_writedata = 32'd0;
  logic        av_waitrequest, av_readdatavalid, ram_wren, jtag_busy, jtag_overrun;
  logic [31:0] av_readdata, ram_wdata, MonDReg;
  logic [7:0]  ram_addr, MonAReg;
  logic [31:0] ram_rdata = 32'd0;
  logic [31:0] mem [0:255] = '{default: 32'd0};
  int          passed = 0, total = 0, failed = 0;

  nios_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_no_a),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .MonAReg(MonAReg), .MonDReg(MonDReg),
    .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h (failure %0d)", tag, obs, exp, failed);
    end
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    return {28'd0, a, 2'b00};
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'd0, d, 3'b000};
  endfunction

  initial begin
    tick(3);
    chk("rst_waitreq", {31'd0, av_waitrequest}, 32'd0);
    chk("rst_rdvalid", {31'd0, av_readdatavalid}, 32'd0);
    chk("rst_readdata", av_readdata, 32'd0);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_mona", {24'd0, MonAReg}, 32'd0);
    chk("rst_mond", MonDReg, 32'd0);
    chk("rst_busy", {31'd0, jtag_busy}, 32'd0);
    chk("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Load address 0x10, then a two-word write burst.
    jdo = jdo_addr(8'h10); take_a = 1'b1; tick(1); take_a = 1'b0;
    chk("load_mona", {24'd0, MonAReg}, 32'h10);
    jdo = jdo_data(32'hDEADBEEF); take_b = 1'b1; tick(1); take_b = 1'b0;
    chk("wr1_busy", {31'd0, jtag_busy}, 32'd1);
    chk("wr1_mond", MonDReg, 32'hDEADBEEF);
    chk("wr1_mona", {24'd0, MonAReg}, 32'h11);
    chk("wr1_wren_early", {31'd0, ram_wren}, 32'd0);
    tick(1);
    chk("wr1_wren", {31'd0, ram_wren}, 32'd1);
    chk("wr1_addr", {24'd0, ram_addr}, 32'h10);
    chk("wr1_wdata", ram_wdata, 32'hDEADBEEF);
    tick(1);
    chk("wr1_wren_off", {31'd0, ram_wren}, 32'd0);
    chk("wr1_busy_off", {31'd0, jtag_busy}, 32'd0);
    tick(2);
    jdo = jdo_data(32'h12345678); take_b = 1'b1; tick(1); take_b = 1'b0;
    tick(3);
    chk("burst_mem10", mem[8'h10], 32'hDEADBEEF);
    chk("burst_mem11", mem[8'h11], 32'h12345678);
    chk("burst_mona", {24'd0, MonAReg}, 32'h12);

    // JTAG read-back of 0x10: MonDReg four cycles after the strobe.
    jdo = jdo_addr(8'h10); take_a = 1'b1; tick(1); take_a = 1'b0;
    take_no_a = 1'b1; tick(1); take_no_a = 1'b0;
    chk("rd_mona", {24'd0, MonAReg}, 32'h11);
    chk("rd_busy1", {31'd0, jtag_busy}, 32'd1);
    tick(2);
    chk("rd_mond_early", MonDReg, 32'h12345678);
    chk("rd_busy3", {31'd0, jtag_busy}, 32'd1);
    tick(1);
    chk("rd_mond", MonDReg, 32'hDEADBEEF);
    chk("rd_busy_off", {31'd0, jtag_busy}, 32'd0);

    // Avalon write then read of 0x05.
    av_address = 8'h05; av_writedata = 32'hCAFEF00D; av_write = 1'b1; #1;
    chk("awr_wait_idle", {31'd0, av_waitrequest}, 32'd1);
    tick(1);
    chk("awr_wait", {31'd0, av_waitrequest}, 32'd0);
    chk("awr_wren", {31'd0, ram_wren}, 32'd1);
    chk("awr_addr", {24'd0, ram_addr}, 32'h05);
    av_write = 1'b0; tick(1);
    chk("awr_mem5", mem[8'h05], 32'hCAFEF00D);
    av_read = 1'b1; tick(1);
    chk("ard_wait", {31'd0, av_waitrequest}, 32'd0);
    av_read = 1'b0; tick(1);
    chk("ard_valid_early", {31'd0, av_readdatavalid}, 32'd0);
    tick(1);
    chk("ard_valid", {31'd0, av_readdatavalid}, 32'd1);
    chk("ard_data", av_readdata, 32'hCAFEF00D);
    tick(1);
    chk("ard_valid_pulse", {31'd0, av_readdatavalid}, 32'd0);

    // Tie with last grant Avalon: JTAG write to 0x20 first.
    jdo = jdo_addr(8'h20); take_a = 1'b1; tick(1); take_a = 1'b0;
    jdo = jdo_data(32'hA5A5A5A5); take_b = 1'b1; tick(1); take_b = 1'b0;
    av_address = 8'h05; av_read = 1'b1; #1;
    chk("tie1_wait0", {31'd0, av_waitrequest}, 32'd1);
    tick(1);
    chk("tie1_jwren", {31'd0, ram_wren}, 32'd1);
    chk("tie1_jaddr", {24'd0, ram_addr}, 32'h20);
    chk("tie1_wait1", {31'd0, av_waitrequest}, 32'd1);
    tick(1);
    chk("tie1_wait2", {31'd0, av_waitrequest}, 32'd1);
    tick(1);
    chk("tie1_accept", {31'd0, av_waitrequest}, 32'd0);
    chk("tie1_aaddr", {24'd0, ram_addr}, 32'h05);
    av_read = 1'b0; tick(2);
    chk("tie1_valid", {31'd0, av_readdatavalid}, 32'd1);
    chk("tie1_data", av_readdata, 32'hCAFEF00D);
    chk("tie1_mem20", mem[8'h20], 32'hA5A5A5A5);

    // JTAG-only write to 0x21, then tie with last grant JTAG: Avalon first.
    jdo = jdo_data(32'h11111111); take_b = 1'b1; tick(1); take_b = 1'b0;
    tick(3);
    jdo = jdo_data(32'h22222222); take_b = 1'b1; tick(1); take_b = 1'b0;
    av_address = 8'h06; av_writedata = 32'h66666666; av_write = 1'b1; #1;
    chk("tie2_wait0", {31'd0, av_waitrequest}, 32'd1);
    tick(1);
    chk("tie2_awren", {31'd0, ram_wren}, 32'd1);
    chk("tie2_aaddr", {24'd0, ram_addr}, 32'h06);
    chk("tie2_awdata", ram_wdata, 32'h66666666);
    chk("tie2_accept", {31'd0, av_waitrequest}, 32'd0);
    chk("tie2_busy", {31'd0, jtag_busy}, 32'd1);
    av_write = 1'b0; tick(2);
    chk("tie2_jwren", {31'd0, ram_wren}, 32'd1);
    chk("tie2_jaddr", {24'd0, ram_addr}, 32'h22);
    chk("tie2_jwdata", ram_wdata, 32'h22222222);
    tick(1);
    chk("tie2_mem6", mem[8'h06], 32'h66666666);
    chk("tie2_mem21", mem[8'h21], 32'h11111111);
    chk("tie2_mem22", mem[8'h22], 32'h22222222);

    // Overrun: back-to-back write strobes while Avalon write holds the RAM.
    av_address = 8'h07; av_writedata = 32'h00000077; av_write = 1'b1;
    jdo = jdo_data(32'h000000B1); take_b = 1'b1; tick(1);
    chk("ovr_none_yet", {31'd0, jtag_overrun}, 32'd0);
    jdo = jdo_data(32'h000000B2); tick(1);
    take_b = 1'b0; av_write = 1'b0;
    chk("ovr_flag", {31'd0, jtag_overrun}, 32'd1);
    chk("ovr_mona", {24'd0, MonAReg}, 32'h24);
    chk("ovr_mond", MonDReg, 32'h000000B1);
    tick(1);
    chk("ovr_jaddr", {24'd0, ram_addr}, 32'h23);
    chk("ovr_jwdata", ram_wdata, 32'h000000B1);
    tick(1);
    chk("ovr_mem23", mem[8'h23], 32'h000000B1);
    chk("ovr_mem24", mem[8'h24], 32'd0);
    chk("ovr_mem7", mem[8'h07], 32'h00000077);

    // Address wrap at 0xFF.
    jdo = jdo_addr(8'hFF); take_a = 1'b1; tick(1); take_a = 1'b0;
    jdo = jdo_data(32'hFEEDFACE); take_b = 1'b1; tick(1); take_b = 1'b0;
    chk("wrap_mona", {24'd0, MonAReg}, 32'h00);
    tick(1);
    chk("wrap_addr", {24'd0, ram_addr}, 32'hFF);
    tick(1);
    chk("wrap_memff", mem[8'hFF], 32'hFEEDFACE);

    // Simultaneous load and read: read uses old address 0x00, load wins MonAReg.
    jdo = jdo_addr(8'h30); take_a = 1'b1; take_no_a = 1'b1; tick(1);
    take_a = 1'b0; take_no_a = 1'b0;
    chk("simul_mona", {24'd0, MonAReg}, 32'h30);
    tick(3);
    chk("simul_mond", MonDReg, 32'd0);
    chk("simul_busy", {31'd0, jtag_busy}, 32'd0);

    // Reset during J_RD_CAP, then a normal Avalon read.
    jdo = jdo_addr(8'h10); take_a = 1'b1; tick(1); take_a = 1'b0;
    take_no_a = 1'b1; tick(1); take_no_a = 1'b0;
    tick(2);
    chk("mid_busy", {31'd0, jtag_busy}, 32'd1);
    reset_n = 1'b0; #1;
    chk("mid_mona", {24'd0, MonAReg}, 32'd0);
    chk("mid_mond", MonDReg, 32'd0);
    chk("mid_busy_off", {31'd0, jtag_busy}, 32'd0);
    chk("mid_overrun", {31'd0, jtag_overrun}, 32'd0);
    chk("mid_addr", {24'd0, ram_addr}, 32'd0);
    chk("mid_wren", {31'd0, ram_wren}, 32'd0);
    chk("mid_readdata", av_readdata, 32'd0);
    chk("mid_waitreq", {31'd0, av_waitrequest}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    av_address = 8'h10; av_read = 1'b1; tick(1);
    chk("post_accept", {31'd0, av_waitrequest}, 32'd0);
    av_read = 1'b0; tick(2);
    chk("post_valid", {31'd0, av_readdatavalid}, 32'd1);
    chk("post_data", av_readdata, 32'hDEADBEEF);
    chk("post_mond", MonDReg, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
